lcd_text_buffer: RTL and testbench
==================================

# lcd_text_buffer

Character-stream front end for the 16x2 LCD path. Accepts ASCII bytes one at a time over a valid/ready handshake, interprets a small set of control codes, and maintains the 32-cell, 256-bit frame buffer that feeds `LCD_MODULE.iFB`. It sits directly upstream of `LCD_MODULE` and replaces hard-wired frame-buffer constants with a writable text console.

## Interface
Parameters:
- `WRAP`, default 1: 1 = the cursor wraps from 31 to 0; 0 = the cursor saturates at 31, and later printable characters overwrite cell 31.
- `FILL_CHAR`, default 8'h20: the byte written by reset and by the clear sweep.

Ports:
- `iCLK`  in  1: system clock (50 MHz).
- `iRST_N`  in  1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `iCHAR`  in  8: input character byte.
- `iVALID`  in  1: `iCHAR` is valid.
- `oREADY`  out  1: the block can accept a byte this cycle.
- `oFB`  out  256: frame buffer. Cell k is at `oFB[8k+7:8k]`. Cells 0–15 are line 1 and cells 16–31 are line 2. Connects to `LCD_MODULE.iFB`.
- `oCURSOR`  out  5: current write position, 0–31.

## Operation
- Transfer occurs on a rising edge with `iVALID && oREADY`. No other condition consumes `iCHAR`.
- States:
  - IDLE: `oREADY`=1.
  - CLEAR: `oREADY`=0.
- Accepted byte in IDLE:
  - Printable, 0x20–0x7E: write to cell `oCURSOR`, then advance the cursor.
    - WRAP=1: 31 -> 0.
    - WRAP=0: 31 -> 31.
  - 0x0D (CR): cursor -> start of the current line (0 or 16). No cell changes.
  - 0x0A (LF): cursor -> next line, column 0.
    - Line 1 -> 16.
    - Line 2 -> 0 if WRAP=1, else unchanged.
  - 0x08 (BS): cursor -1, saturating at 0. No cell changes.
  - 0x0C (FF): enter CLEAR with sweep counter = 0.
  - Any other byte: consumed and ignored. No state change.
- CLEAR:
  - Each cycle, write `FILL_CHAR` to cell[sweep] and increment sweep.
  - After cell 31 is written (32 cycles): cursor -> 0, return to IDLE.
  - `iVALID` is ignored throughout; the upstream holds its byte.
- Cursor arithmetic is 5-bit unsigned. Line = `oCURSOR[4]`, column = `oCURSOR[3:0]`.

## Timing
- Reset values:
  - All cells = `FILL_CHAR`, so `oFB` = {32{FILL_CHAR}}.
  - `oCURSOR` = 0, state = IDLE, `oREADY` = 1.
- `oFB` and `oCURSOR` are registered. The effect of a transfer on edge N is visible after edge N.
- Throughput is one byte per cycle in IDLE.
- FF accepted on edge N:
  - `oREADY` is low after edge N through edge N+32.
  - `oREADY` is high again after edge N+32.
  - The earliest next transfer is on edge N+33.
- During CLEAR, cells not yet swept keep their old contents. `LCD_MODULE` may display a partial clear; this is acceptable.
- Reset asserted mid-CLEAR or mid-stream: all registers take their reset values immediately (asynchronously), and the sweep is abandoned.
- `oREADY` is a decode of the state register. It has no combinational path from `iVALID` or `iCHAR`.

## Structure
- Shared package `lcd_pkg`:
  - `LCD_COLS`=16, `LCD_CELLS`=32.
  - Character constants: `CHR_BS`=8'h08, `CHR_LF`=8'h0A, `CHR_FF`=8'h0C, `CHR_CR`=8'h0D, `CHR_SP`=8'h20, `CHR_DEL`=8'h7F.
  - State enum: {IDLE, CLEAR}.
- No sub-module. The block is a single cell register array, 32x8, plus cursor, sweep counter and a 2-state FSM.
- Top-level integration: `Reset_Delay.oRESET` drives both `iRST_N` and `LCD_MODULE.iRST_N`.

## Test plan
- Reset and release:
  - `oFB` = 256'h2020...20, `oCURSOR`=0, `oREADY`=1.
  - Hold `iVALID`=0 for 100 cycles: no change.
- Send 0x41, 0x42 back-to-back:
  - Next cycle `oFB[7:0]`=0x41 and `oFB[15:8]`=0x42.
  - `oCURSOR`=2; all other cells stay 0x20.
- Line handling:
  - Send 16 x 0x78, then 0x59: `oFB[135:128]`=0x59, `oCURSOR`=17.
  - Then CR: `oCURSOR`=16.
  - Then LF: `oCURSOR`=0 (WRAP=1).
- Clear:
  - With all cells 0x78, send 0x0C and hold `iVALID`=1 with 0x5A behind it.
  - `oREADY` is low exactly 32 cycles.
  - Then `oFB` = {31{0x20}},0x5A at cell 0, and `oCURSOR`=1.
- Wrap and saturation:
  - WRAP=1: 33 x 0x51 gives cell 0 = 0x51 and `oCURSOR`=1.
  - WRAP=0 instance: 33 x 0x51 gives `oCURSOR`=31.
  - BS at cursor 0 leaves 0; byte 0x01 is ignored.
- Reset mid-CLEAR:
  - Assert `iRST_N`=0 ten cycles into a sweep.
  - `oFB` = all 0x20, `oCURSOR`=0 immediately.
  - `oREADY`=1 after release.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared geometry, character codes and state type for the LCD path.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int LCD_COLS  = 16;
    localparam int LCD_CELLS = 32;

    localparam logic [7:0] CHR_BS  = 8'h08;
    localparam logic [7:0] CHR_LF  = 8'h0A;
    localparam logic [7:0] CHR_FF  = 8'h0C;
    localparam logic [7:0] CHR_CR  = 8'h0D;
    localparam logic [7:0] CHR_SP  = 8'h20;
    localparam logic [7:0] CHR_DEL = 8'h7F;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } lcd_state_t;

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_text_buffer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_text_buffer
// Purpose  : Byte-stream text console maintaining the 32-cell LCD frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_text_buffer
    import lcd_pkg::*;
#(
    parameter int         WRAP      = 1,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic [7:0]   iCHAR,
    input  logic         iVALID,
    output logic         oREADY,
    output logic [255:0] oFB,
    output logic [4:0]   oCURSOR
);

    lcd_state_t  r_state;
    logic [4:0]  r_cursor;
    logic [4:0]  r_sweep;
    logic [7:0]  r_cells [LCD_CELLS];

    lcd_state_t  w_next_state;
    logic [4:0]  w_next_cursor;
    logic [4:0]  w_next_sweep;
    logic        w_wr_en;
    logic [4:0]  w_wr_addr;
    logic [7:0]  w_wr_data;
    logic        w_printable;
    logic [4:0]  w_cursor_inc;

    assign w_printable  = (iCHAR >= CHR_SP) && (iCHAR < CHR_DEL);
    // Without wrap the cursor parks on the last cell so it keeps getting overwritten.
    assign w_cursor_inc = ((WRAP == 0) && (r_cursor == 5'(LCD_CELLS - 1))) ?
                          r_cursor : r_cursor + 5'd1;

    always_comb begin
        w_next_state  = r_state;
        w_next_cursor = r_cursor;
        w_next_sweep  = r_sweep;
        w_wr_en       = 1'b0;
        w_wr_addr     = r_cursor;
        w_wr_data     = iCHAR;
        case (r_state)
            IDLE: begin
                if (iVALID) begin
                    if (w_printable) begin
                        w_wr_en       = 1'b1;
                        w_next_cursor = w_cursor_inc;
                    end else begin
                        case (iCHAR)
                            CHR_CR: w_next_cursor = {r_cursor[4], 4'd0};
                            CHR_LF: begin
                                if (!r_cursor[4])
                                    w_next_cursor = 5'(LCD_COLS);
                                else if (WRAP != 0)
                                    w_next_cursor = 5'd0;
                            end
                            CHR_BS: begin
                                if (r_cursor != 5'd0)
                                    w_next_cursor = r_cursor - 5'd1;
                            end
                            CHR_FF: begin
                                w_next_state = CLEAR;
                                w_next_sweep = 5'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                w_wr_en      = 1'b1;
                w_wr_addr    = r_sweep;
                w_wr_data    = FILL_CHAR;
                w_next_sweep = r_sweep + 5'd1;
                if (r_sweep == 5'(LCD_CELLS - 1)) begin
                    w_next_state  = IDLE;
                    w_next_cursor = 5'd0;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state  <= IDLE;
            r_cursor <= 5'd0;
            r_sweep  <= 5'd0;
            for (int k = 0; k < LCD_CELLS; k++)
                r_cells[k] <= FILL_CHAR;
        end else begin
            r_state  <= w_next_state;
            r_cursor <= w_next_cursor;
            r_sweep  <= w_next_sweep;
            if (w_wr_en)
                r_cells[w_wr_addr] <= w_wr_data;
        end
    end

    assign oREADY  = (r_state == IDLE);
    assign oCURSOR = r_cursor;

    for (genvar k = 0; k < LCD_CELLS; k++) begin : g_fb
        assign oFB[8*k +: 8] = r_cells[k];
    end

endmodule : lcd_text_buffer
`default_nettype wire

// File: tb/tb_lcd_text_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_text_buffer
// Purpose  : Randomized and directed checks of lcd_text_buffer (WRAP=1 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_text_buffer;
    import lcd_pkg::*;

    logic         iCLK = 1'b0;
    logic         iRST_N;
    logic [7:0]   iCHAR;
    logic         iVALID;
    logic         ready_q [2];
    logic [255:0] fb_q    [2];
    logic [4:0]   cur_q   [2];

    // Instance 0 wraps, instance 1 saturates; both see the same byte stream.
    lcd_text_buffer #(.WRAP(1), .FILL_CHAR(8'h20)) u_wrap (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCHAR(iCHAR), .iVALID(iVALID),
        .oREADY(ready_q[0]), .oFB(fb_q[0]), .oCURSOR(cur_q[0])
    );
    lcd_text_buffer #(.WRAP(0), .FILL_CHAR(8'h20)) u_sat (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCHAR(iCHAR), .iVALID(iVALID),
        .oREADY(ready_q[1]), .oFB(fb_q[1]), .oCURSOR(cur_q[1])
    );

    always #5 iCLK = ~iCLK;

    logic [7:0] m_cell [2][32];
    int         m_cur  [2];
    int         m_clr  [2];
    int         total = 0;
    int         bad   = 0;

    function automatic logic [255:0] exp_fb(int i);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = m_cell[i][k];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 32; k++) m_cell[i][k] = 8'h20;
            m_cur[i] = 0;
            m_clr[i] = 0;
        end
    endtask

    task automatic model_edge(input logic v, input logic [7:0] c);
        for (int i = 0; i < 2; i++) begin
            if (m_clr[i] > 0) begin
                m_cell[i][32 - m_clr[i]] = 8'h20;
                m_clr[i]--;
                if (m_clr[i] == 0) m_cur[i] = 0;
            end else if (v) begin
                if (c >= 8'h20 && c <= 8'h7E) begin
                    m_cell[i][m_cur[i]] = c;
                    if (i == 0) m_cur[i] = (m_cur[i] + 1) % 32;
                    else        m_cur[i] = (m_cur[i] == 31) ? 31 : m_cur[i] + 1;
                end else if (c == 8'h0D) m_cur[i] = (m_cur[i] / 16) * 16;
                else if (c == 8'h0A) begin
                    if (m_cur[i] < 16) m_cur[i] = 16;
                    else if (i == 0)   m_cur[i] = 0;
                end else if (c == 8'h08) m_cur[i] = (m_cur[i] > 0) ? m_cur[i] - 1 : 0;
                else if (c == 8'h0C) m_clr[i] = 32;
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] c);
        iVALID = v;
        iCHAR  = c;
        @(posedge iCLK);
        model_edge(v, c);
        #1;
    endtask

    task automatic do_reset();
        iVALID = 1'b0;
        iCHAR  = 8'h00;
        iRST_N = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        iRST_N = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (fb_q[i] !== {32{8'h20}} || cur_q[i] !== 5'd0 || ready_q[i] !== 1'b1) begin
                bad++;
                $display("FAIL reset[%0d] fb=%h cur=%0d rdy=%b exp all-20/0/1", i, fb_q[i], cur_q[i], ready_q[i]);
            end
        end
        for (int n = 0; n < 100; n++) begin
            step(1'b0, 8'(n));
            total++;
            if (fb_q[0] !== {32{8'h20}} || cur_q[0] !== 5'd0 || ready_q[0] !== 1'b1) begin
                bad++;
                $display("FAIL idle_hold cyc=%0d fb=%h cur=%0d rdy=%b", n, fb_q[0], cur_q[0], ready_q[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 8'h41);
        step(1'b1, 8'h42);
        step(1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (fb_q[i] !== {{30{8'h20}}, 8'h42, 8'h41} || cur_q[i] !== 5'd2) begin
                bad++;
                $display("FAIL b2b[%0d] fb=%h cur=%0d exp cur=2", i, fb_q[i], cur_q[i]);
            end
        end
    endtask

    task automatic test_lines();
        do_reset();
        repeat (16) step(1'b1, 8'h78);
        step(1'b1, 8'h59);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (fb_q[i][135:128] !== 8'h59 || cur_q[i] !== 5'd17) begin
                bad++;
                $display("FAIL line2_char[%0d] cell16=%h cur=%0d exp 59/17", i, fb_q[i][135:128], cur_q[i]);
            end
        end
        step(1'b1, CHR_CR);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (cur_q[i] !== 5'd16) begin
                bad++;
                $display("FAIL cr[%0d] cur=%0d exp 16", i, cur_q[i]);
            end
        end
        step(1'b1, CHR_LF);
        total++;
        if (cur_q[0] !== 5'd0 || cur_q[1] !== 5'd16) begin
            bad++;
            $display("FAIL lf cur_wrap=%0d cur_sat=%0d exp 0/16", cur_q[0], cur_q[1]);
        end
    endtask

    task automatic test_clear();
        int lowcnt;
        do_reset();
        repeat (32) step(1'b1, 8'h78);
        step(1'b1, CHR_FF);
        lowcnt = 0;
        while (ready_q[0] === 1'b0 && lowcnt < 40) begin
            lowcnt++;
            step(1'b1, 8'h5A);
        end
        step(1'b1, 8'h5A);
        step(1'b0, 8'h00);
        total++;
        if (lowcnt != 32) begin
            bad++;
            $display("FAIL clear_ready_low cycles=%0d exp 32", lowcnt);
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (fb_q[i] !== {{31{8'h20}}, 8'h5A} || cur_q[i] !== 5'd1 || fb_q[i] !== exp_fb(i)) begin
                bad++;
                $display("FAIL clear_result[%0d] fb=%h cur=%0d exp cur=1", i, fb_q[i], cur_q[i]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (33) step(1'b1, 8'h51);
        total++;
        if (fb_q[0][7:0] !== 8'h51 || cur_q[0] !== 5'd1) begin
            bad++;
            $display("FAIL wrap cell0=%h cur=%0d exp 51/1", fb_q[0][7:0], cur_q[0]);
        end
        total++;
        if (cur_q[1] !== 5'd31 || fb_q[1] !== {32{8'h51}}) begin
            bad++;
            $display("FAIL saturate cur=%0d fb=%h exp 31/all-51", cur_q[1], fb_q[1]);
        end
        do_reset();
        step(1'b1, CHR_BS);
        step(1'b1, 8'h01);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (cur_q[i] !== 5'd0 || fb_q[i] !== {32{8'h20}} || ready_q[i] !== 1'b1) begin
                bad++;
                $display("FAIL bs_ignore[%0d] cur=%0d fb=%h rdy=%b", i, cur_q[i], fb_q[i], ready_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [7:0] c;
        int         r;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 59);
            if (r == 0)       c = CHR_FF;
            else if (r < 5)   c = CHR_CR;
            else if (r < 9)   c = CHR_LF;
            else if (r < 14)  c = CHR_BS;
            else if (r < 17)  c = 8'($urandom_range(0, 31));
            else if (r < 19)  c = 8'($urandom_range(127, 255));
            else              c = 8'($urandom_range(32, 126));
            step(v, c);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (fb_q[i] !== exp_fb(i) || cur_q[i] !== 5'(m_cur[i]) || ready_q[i] !== (m_clr[i] == 0)) begin
                    bad++;
                    $display("FAIL random[%0d] n=%0d fb=%h exp=%h cur=%0d exp=%0d rdy=%b",
                             i, n, fb_q[i], exp_fb(i), cur_q[i], m_cur[i], ready_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        repeat (20) step(1'b1, 8'h6B);
        step(1'b1, CHR_FF);
        repeat (10) step(1'b0, 8'h00);
        #2;
        iRST_N = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (fb_q[i] !== {32{8'h20}} || cur_q[i] !== 5'd0) begin
                bad++;
                $display("FAIL async_reset[%0d] fb=%h cur=%0d exp all-20/0", i, fb_q[i], cur_q[i]);
            end
        end
        repeat (2) @(posedge iCLK);
        #1;
        iRST_N = 1'b1;
        model_reset();
        step(1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (ready_q[i] !== 1'b1 || fb_q[i] !== {32{8'h20}}) begin
                bad++;
                $display("FAIL post_reset[%0d] rdy=%b fb=%h exp 1/all-20", i, ready_q[i], fb_q[i]);
            end
        end
    endtask

    initial begin
        iRST_N = 1'b1;
        iVALID = 1'b0;
        iCHAR  = 8'h00;
        model_reset();
        #1;
        test_reset();
        test_back_to_back();
        test_lines();
        test_clear();
        test_wrap();
        test_random();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lcd_text_buffer
`default_nettype wire
